// File: rtl/mhp_pkg.sv
// Shared MHP constants and types: default frame limit, frame-length width,
// the reader state encoding and a saturating counter helper.
package mhp_pkg;

  localparam int MHP_MAX_LEN = 1518;
  localparam int MHP_LEN_W   = 11;

  typedef logic [MHP_LEN_W-1:0] frame_len_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACTIVE = 2'd1,
    RD_GAP    = 2'd2
  } rd_state_e;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/mhp_rx_buffer_if.sv
// Receive-buffer bus: MAC receive stream in, byte-pull read port and drop
// status out. The slave side is the buffer, the master side its environment.
interface mhp_rx_buffer_if;

  logic [7:0]  i_mac_data;
  logic        i_mac_valid;
  logic        i_mac_last;
  logic        i_mac_err;
  logic        o_rready;
  logic        i_rreq;
  logic [7:0]  o_rdata;
  logic        o_rvalid;
  logic        o_rlast;
  logic        o_drop;
  logic [15:0] o_drop_cnt;

  modport master (
    output i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
    input  o_rready, o_rdata, o_rvalid, o_rlast, o_drop, o_drop_cnt
  );

  modport slave (
    input  i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
    output o_rready, o_rdata, o_rvalid, o_rlast, o_drop, o_drop_cnt
  );

endinterface

// File: rtl/mhp_rx_buffer_len_fifo.sv
// Small synchronous FIFO of committed frame lengths. The head entry is
// visible combinationally so the reader can load it the cycle it pops.
// DEPTH must be a power of two, at least 2.
module rx_len_fifo
  import mhp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = MHP_LEN_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         push_ok;
  logic         pop_ok;

  assign o_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign o_dout  = mem[rd_ptr_reg[AW-1:0]];
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  // Pointer update; push and pop together leave the occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Length storage.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mhp_rx_buffer.sv
// Receive frame buffer: stores MAC bytes in a circular RAM, commits a frame
// only on an error-free last byte, discards bad frames whole and replays
// committed frames one at a time over the byte-pull port.
module mhp_rx_buffer
  import mhp_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int MAX_LEN        = MHP_MAX_LEN,
  parameter int LEN_FIFO_DEPTH = 8,
  parameter int FRAME_GAP      = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mhp_rx_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(FRAME_GAP + 2);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t       FULL_USED = ptr_t'(DEPTH);
  localparam frame_len_t LEN_LIMIT = frame_len_t'(MAX_LEN + 1);

  logic [7:0]  mem [DEPTH];

  ptr_t        wr_ptr_reg;
  ptr_t        wr_commit_reg;
  ptr_t        rd_ptr_reg;
  frame_len_t  wr_len_reg;
  logic        bad_reg;
  logic        drop_reg;
  logic [15:0] drop_cnt_reg;

  rd_state_e   state_reg;
  rd_state_e   state_next;
  frame_len_t  remaining_reg;
  logic [GW-1:0] gap_reg;
  logic [7:0]  rdata_reg;
  logic        rvalid_reg;
  logic        rlast_reg;

  ptr_t        used;
  frame_len_t  len_inc;
  logic        frame_bad;
  logic        wr_en;
  logic        commit;
  logic        discard;

  logic        rready;
  logic        pop;
  logic        len_pop;
  logic        frame_done;
  frame_len_t  len_dout;
  logic        len_full;
  logic        len_empty;

  // Bytes held between the reader and the write head (committed + pending).
  assign used = wr_ptr_reg - rd_ptr_reg;

  rx_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH),
    .W     (MHP_LEN_W)
  ) u_len_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (commit),
    .i_din   (len_inc),
    .i_pop   (len_pop),
    .o_dout  (len_dout),
    .o_full  (len_full),
    .o_empty (len_empty)
  );

  // Classify the incoming byte: keep writing, commit, or discard the frame.
  always_comb begin
    len_inc   = (wr_len_reg == LEN_LIMIT) ? wr_len_reg : wr_len_reg + 1'b1;
    frame_bad = bad_reg | (used == FULL_USED) | (len_inc == LEN_LIMIT) |
                (bus.i_mac_last & len_full);
    wr_en     = bus.i_mac_valid & ~frame_bad;
    commit    = bus.i_mac_valid & bus.i_mac_last & ~frame_bad & ~bus.i_mac_err;
    discard   = bus.i_mac_valid & bus.i_mac_last & (frame_bad | bus.i_mac_err);
  end

  // Write pointer, commit point, frame length and drop accounting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      wr_len_reg    <= '0;
      bad_reg       <= 1'b0;
      drop_reg      <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      drop_reg <= discard;
      if (discard) drop_cnt_reg <= sat_inc16(drop_cnt_reg);
      if (bus.i_mac_valid) begin
        if (bus.i_mac_last) begin
          wr_len_reg <= '0;
          bad_reg    <= 1'b0;
          if (commit) begin
            wr_ptr_reg    <= wr_ptr_reg + 1'b1;
            wr_commit_reg <= wr_ptr_reg + 1'b1;
          end else begin
            // Rewind so the discarded frame's bytes are reused.
            wr_ptr_reg <= wr_commit_reg;
          end
        end else begin
          wr_len_reg <= len_inc;
          bad_reg    <= frame_bad;
          if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
      end
    end
  end

  // Byte store write port.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= bus.i_mac_data;
  end

  // Byte store registered read port.
  always_ff @(posedge i_clk) begin
    if (i_rst)    rdata_reg <= '0;
    else if (pop) rdata_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  // Reader state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= RD_IDLE;
    else       state_reg <= state_next;
  end

  // Reader next-state: load a frame, stream it, then hold the inter-frame gap.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE:   if (!len_empty && gap_reg == '0) state_next = RD_ACTIVE;
      RD_ACTIVE: if (frame_done)                  state_next = RD_GAP;
      RD_GAP:    if (gap_reg <= GW'(1))           state_next = RD_IDLE;
      default:   state_next = RD_IDLE;
    endcase
  end

  // Reader outputs: ready, accepted pop, length-FIFO pop, final-byte pop.
  always_comb begin
    rready     = (state_reg == RD_ACTIVE) && (remaining_reg != '0);
    pop        = rready & bus.i_rreq;
    len_pop    = (state_reg == RD_IDLE) && !len_empty && (gap_reg == '0);
    frame_done = pop && (remaining_reg == frame_len_t'(1));
  end

  // Reader datapath: remaining count, gap timer, read pointer, output flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining_reg <= '0;
      gap_reg       <= '0;
      rd_ptr_reg    <= '0;
      rvalid_reg    <= 1'b0;
      rlast_reg     <= 1'b0;
    end else begin
      if (len_pop)  remaining_reg <= len_dout;
      else if (pop) remaining_reg <= remaining_reg - 1'b1;
      if (frame_done) gap_reg <= GW'(FRAME_GAP);
      else if (state_reg == RD_GAP && gap_reg != '0) gap_reg <= gap_reg - 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      rvalid_reg <= pop;
      rlast_reg  <= frame_done;
    end
  end

  assign bus.o_rready   = rready;
  assign bus.o_rdata    = rdata_reg;
  assign bus.o_rvalid   = rvalid_reg;
  assign bus.o_rlast    = rlast_reg;
  assign bus.o_drop     = drop_reg;
  assign bus.o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_mhp_rx_buffer.sv
// Directed bench for mhp_rx_buffer. Expected frames are queued as bytes with
// a last flag; the monitor checks every delivered byte, gap and drop against
// that queue, and the main sequence pins counts and boundary bytes literally.
module tb_mhp_rx_buffer;

  localparam int DEPTH     = 64;
  localparam int MAX_LEN   = 48;
  localparam int LFD       = 8;
  localparam int FRAME_GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mhp_rx_buffer_if bus();

  mhp_rx_buffer #(
    .DEPTH          (DEPTH),
    .MAX_LEN        (MAX_LEN),
    .LEN_FIFO_DEPTH (LFD),
    .FRAME_GAP      (FRAME_GAP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          beat_cnt = 0;
  int          drop_seen = 0;
  int          gap_left = 0;
  logic [7:0]  last_rlast_byte = 8'h00;
  logic        last_drop = 1'b0;
  logic        sent_rready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected byte stream.
  always @(negedge clk) begin
    logic [8:0] e;
    if (bus.o_rvalid) begin
      beat_cnt++;
      got_q.push_back(bus.o_rdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_pop actual=0x%0h required=no_beat", bus.o_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rdata", {24'd0, bus.o_rdata}, {24'd0, e[7:0]});
        check("rlast", {31'd0, bus.o_rlast}, {31'd0, e[8]});
      end
      if (bus.o_rlast) begin
        gap_left = FRAME_GAP;
        last_rlast_byte = bus.o_rdata;
      end
    end
    if (gap_left > 0) begin
      check("gap_rready", {31'd0, bus.o_rready}, 32'd0);
      gap_left--;
    end
    if (bus.o_rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rready_no_frame actual=1 required=0");
      end
    end
    if (bus.o_drop) begin
      drop_seen++;
      check("drop_cnt_track", {16'd0, bus.o_drop_cnt}, 32'(drop_seen));
    end
    if (rst) begin
      exp_q.delete();
      gap_left = 0;
      drop_seen = 0;
    end
  end

  task automatic send_frame(input logic [7:0] base, input int len, input bit err, input bit keep);
    if (keep)
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), 8'(base + 8'(i))});
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.i_mac_valid = 1'b1;
      bus.i_mac_data  = 8'(base + 8'(i));
      bus.i_mac_last  = (i == len - 1);
      bus.i_mac_err   = err && (i == len - 1);
    end
    @(negedge clk);
    bus.i_mac_valid = 1'b0;
    bus.i_mac_last  = 1'b0;
    bus.i_mac_err   = 1'b0;
    last_drop   = bus.o_drop;
    sent_rready = bus.o_rready;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_bytes_left required=0", name, exp_q.size());
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rready"},   {31'd0, bus.o_rready},   32'd0);
    check({tag, "_rdata"},    {24'd0, bus.o_rdata},    32'd0);
    check({tag, "_rvalid"},   {31'd0, bus.o_rvalid},   32'd0);
    check({tag, "_rlast"},    {31'd0, bus.o_rlast},    32'd0);
    check({tag, "_drop"},     {31'd0, bus.o_drop},     32'd0);
    check({tag, "_drop_cnt"}, {16'd0, bus.o_drop_cnt}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int g0;
    int c;
    bus.i_mac_data  = 8'h00;
    bus.i_mac_valid = 1'b0;
    bus.i_mac_last  = 1'b0;
    bus.i_mac_err   = 1'b0;
    bus.i_rreq      = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 37-byte frame, commit latency, then continuous pull.
    b0 = beat_cnt; g0 = got_q.size();
    send_frame(8'h00, 37, 1'b0, 1'b1);
    check("t1_no_drop", {31'd0, last_drop}, 32'd0);
    check("t1_rready_t1", {31'd0, sent_rready}, 32'd0);
    @(negedge clk);
    check("t1_rready_t2", {31'd0, bus.o_rready}, 32'd1);
    bus.i_rreq = 1'b1;
    drain("t1", 200);
    check("t1_beats", 32'(beat_cnt - b0), 32'd37);
    check("t1_first", {24'd0, got_q[g0]}, 32'h00);
    check("t1_lastbyte", {24'd0, last_rlast_byte}, 32'h24);

    // Errored frame dropped, following good frame delivered.
    b0 = beat_cnt;
    send_frame(8'h60, 20, 1'b1, 1'b0);
    check("t2_drop_pulse", {31'd0, last_drop}, 32'd1);
    send_frame(8'hA0, 10, 1'b0, 1'b1);
    check("t2_good_no_drop", {31'd0, last_drop}, 32'd0);
    drain("t2", 200);
    check("t2_beats", 32'(beat_cnt - b0), 32'd10);
    check("t2_drop_cnt", {16'd0, bus.o_drop_cnt}, 32'd1);
    check("t2_lastbyte", {24'd0, last_rlast_byte}, 32'hA9);

    // Overflow: A kept, B overflows the 64-byte store and is dropped.
    bus.i_rreq = 1'b0;
    apply_reset();
    b0 = beat_cnt;
    send_frame(8'h20, 40, 1'b0, 1'b1);
    send_frame(8'h70, 40, 1'b0, 1'b0);
    check("t3_drop_pulse", {31'd0, last_drop}, 32'd1);
    check("t3_drop_cnt", {16'd0, bus.o_drop_cnt}, 32'd1);
    bus.i_rreq = 1'b1;
    drain("t3a", 200);
    check("t3_beats_a", 32'(beat_cnt - b0), 32'd40);
    check("t3_lastbyte_a", {24'd0, last_rlast_byte}, 32'h47);
    b0 = beat_cnt;
    send_frame(8'hC0, 20, 1'b0, 1'b1);
    check("t3_new_no_drop", {31'd0, last_drop}, 32'd0);
    drain("t3b", 200);
    check("t3_beats_new", 32'(beat_cnt - b0), 32'd20);
    check("t3_lastbyte_new", {24'd0, last_rlast_byte}, 32'hD3);

    // Length limit: MAX_LEN bytes kept, MAX_LEN+1 dropped.
    b0 = beat_cnt;
    send_frame(8'h10, 48, 1'b0, 1'b1);
    check("len_max_no_drop", {31'd0, last_drop}, 32'd0);
    drain("len_max", 200);
    check("len_max_beats", 32'(beat_cnt - b0), 32'd48);
    check("len_max_lastbyte", {24'd0, last_rlast_byte}, 32'h3F);
    b0 = beat_cnt;
    send_frame(8'h50, 49, 1'b0, 1'b0);
    check("len_over_drop", {31'd0, last_drop}, 32'd1);
    check("len_over_cnt", {16'd0, bus.o_drop_cnt}, 32'd2);
    repeat (20) @(negedge clk);
    check("len_over_beats", 32'(beat_cnt - b0), 32'd0);

    // Two 5-byte frames back to back; request held through each gap.
    bus.i_rreq = 1'b0;
    b0 = beat_cnt;
    send_frame(8'h01, 5, 1'b0, 1'b1);
    send_frame(8'h11, 5, 1'b0, 1'b1);
    bus.i_rreq = 1'b1;
    drain("t4", 200);
    repeat (20) @(negedge clk);
    check("t4_beats", 32'(beat_cnt - b0), 32'd10);
    check("t4_lastbyte", {24'd0, last_rlast_byte}, 32'h15);

    // Reset after 8 pops of a 37-byte frame.
    bus.i_rreq = 1'b0;
    send_frame(8'h40, 37, 1'b0, 1'b1);
    b0 = beat_cnt;
    bus.i_rreq = 1'b1;
    c = 0;
    while ((beat_cnt - b0) < 8 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("t6_reached_8", {31'd0, ((beat_cnt - b0) >= 8)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("t6_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    b0 = beat_cnt; g0 = got_q.size();
    send_frame(8'h80, 37, 1'b0, 1'b1);
    drain("t6", 200);
    check("t6_beats", 32'(beat_cnt - b0), 32'd37);
    check("t6_first", {24'd0, got_q[g0]}, 32'h80);
    check("t6_lastbyte", {24'd0, last_rlast_byte}, 32'hA4);

    // Pointer wrap: fifty 13-byte frames with concurrent reading.
    b0 = beat_cnt; g0 = got_q.size();
    for (int k = 0; k < 50; k++) begin
      send_frame(8'((k * 13) & 255), 13, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
    end
    drain("t5", 1000);
    check("t5_beats", 32'(beat_cnt - b0), 32'd650);
    check("t5_drop_cnt", {16'd0, bus.o_drop_cnt}, 32'd0);
    check("t5_byte_300", {24'd0, got_q[g0 + 300]}, 32'h2C);
    check("t5_lastbyte", {24'd0, last_rlast_byte}, 32'h89);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mhp_rx_buffer.md
# mhp_rx_buffer

Receive-side frame buffer between the Ethernet MAC receive stream and the MHP protocol controller. It stores incoming bytes in a circular buffer and commits a frame only after its final byte arrives error-free. It then presents committed frames one at a time on the byte-pull interface (`o_rready`/`i_rreq`/`o_rdata`) that the controller and the frame decoder consume. Frames that are errored, oversized or overflowing are discarded whole, so downstream logic never sees a partial frame.

## Interface

Parameters:
- `DEPTH`, 2048: byte storage in bytes; power of two.
- `MAX_LEN`, 1518: longest accepted frame in bytes; longer frames are dropped.
- `LEN_FIFO_DEPTH`, 8: maximum number of committed frames held at once; power of two.
- `FRAME_GAP`, 2: minimum number of cycles `o_rready` stays low between two frames.

Ports (reset `i_rst`, synchronous, active-high; clock `i_clk`):
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: synchronous active-high reset.
- `i_mac_data`, in, 8: received byte.
- `i_mac_valid`, in, 1: byte strobe; there is no backpressure.
- `i_mac_last`, in, 1: qualifies the final byte of a frame.
- `i_mac_err`, in, 1: frame bad (FCS or PHY error); sampled with `i_mac_last`.
- `o_rready`, out, 1: the current frame has unread bytes.
- `i_rreq`, in, 1: pop one byte.
- `o_rdata`, out, 8: popped byte, registered.
- `o_rvalid`, out, 1: `o_rdata` is valid this cycle.
- `o_rlast`, out, 1: `o_rdata` is the last byte of the frame.
- `o_drop`, out, 1: one-cycle pulse each time a frame is discarded.
- `o_drop_cnt`, out, 16: saturating count of dropped frames.

## Operation

- **Write side.**
  - Bytes are written at `wr_ptr`. `wr_commit` marks the start of the uncommitted frame, and `wr_len` counts its bytes.
  - A frame is marked bad if any of these occur: a write would make `wr_ptr` equal `rd_ptr` (buffer full), `wr_len` reaches `MAX_LEN + 1`, or the length FIFO is full when `i_mac_last` arrives.
  - Once a frame is marked bad, its further bytes are not written.
  - On `i_mac_last`:
    - Good frame: `wr_commit` moves to `wr_ptr + 1`, and the frame length is pushed into the length FIFO.
    - Bad frame or `i_mac_err`: `wr_ptr` rewinds to `wr_commit`, `o_drop` pulses, and `o_drop_cnt` increments (holding at 0xFFFF).
- **Read-side states.**
  - `IDLE`: if the length FIFO is not empty and the gap counter is 0, pop it into `remaining` and go to `ACTIVE`.
  - `ACTIVE`: `o_rready = (remaining != 0)`.
    - Each `i_rreq` with `o_rready=1` reads `rd_ptr`, increments `rd_ptr` (wrapping modulo `DEPTH`) and decrements `remaining`.
    - When `remaining` reaches 0, load the gap counter with `FRAME_GAP` and go to `GAP`.
  - `GAP`: decrement the gap counter; go to `IDLE` when it reaches 0.
- **Ignored requests.** `i_rreq` while `o_rready=0` is ignored: no pop and no `o_rvalid`. This absorbs the controller's registered trailing request.
- **Pointer widths.** Pointers are log2(`DEPTH`) bits and wrap silently. Full and empty are distinguished by an extra wrap bit.
- **Simultaneous events.** A commit and a pop in the same cycle both take effect. A length-FIFO push and pop in the same cycle keeps the FIFO count unchanged.
- **Reset mid-operation.** All pointers, the length FIFO and the state are cleared. Partial and committed frames are lost. Outputs go to 0.

## Timing

- **Reset values.** `o_rready=0`, `o_rdata=0`, `o_rvalid=0`, `o_rlast=0`, `o_drop=0`, `o_drop_cnt=0`.
- **Read latency.** `i_rreq` accepted at cycle t produces `o_rdata`/`o_rvalid` at t+1. `o_rlast` is asserted with the byte that takes `remaining` to 0.
- **Frame end.** After the last pop at t, `o_rready=0` from t+1 and stays low for at least `FRAME_GAP` cycles.
- **Commit latency.** With `i_mac_last` accepted at t and the reader in `IDLE` with no gap pending, `o_rready` rises at t+2.
- **Drop timing.** `o_drop` pulses at t+1 after the offending `i_mac_last`.
- **Throughput.** The read side sustains one byte per cycle, and the write side one byte per cycle, concurrently.

## Structure

- **Shared package `mhp_pkg`.** Holds the constants `MAX_LEN` default and the frame-length width (11 bits), shared with the frame decoder and the assembler.
- **Sub-module `rx_len_fifo`.** A synchronous FIFO, `LEN_FIFO_DEPTH` × 11 bits, with `full`, `empty` and push/pop ports.
- **Byte store.** Inferred single-clock dual-port RAM with registered read.

## Test plan

1. **Single frame.** Send a 37-byte frame 0x00..0x24, then pull continuously. Expect `o_rready` high 37 pops, `o_rdata` 0x00..0x24, `o_rlast` on 0x24, then `o_rready=0` for ≥2 cycles.
2. **Error frame.** Send a 20-byte frame with `i_mac_err` on its last byte, then a good 10-byte frame. Expect 1 `o_drop` pulse and `o_drop_cnt=1`; only the 10 bytes are delivered.
3. **Overflow.** With `DEPTH=64` and no reads, send 40-byte frames A and B. Expect A kept, B dropped (`o_drop_cnt=1`); reading delivers A only, and the buffer accepts a new 20-byte frame afterwards.
4. **Back-to-back with trailing request.** Commit two 5-byte frames and hold `i_rreq` high for one cycle past the end of each frame. Expect exactly 10 `o_rvalid` beats and no extra pop.
5. **Pointer wrap.** With `DEPTH=64`, send fifty 13-byte frames while reading concurrently. Expect all 650 bytes in order and `o_drop_cnt=0`.
6. **Reset mid-frame.** Assert `i_rst` after 8 pops of a 37-byte frame. Expect all outputs 0; the next frame is delivered intact from its first byte.
